// File: rtl/spi_pkg.sv
// Shared types and defaults for the multi-slave SPI main controller.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int MAX_BITS_DEF = 258;
    localparam int DIV_DEF      = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period down-counter that strobes the leading and
// trailing edges and toggles sclk while enabled. When disabled, sclk parks
// at idle_lvl and the counter reloads, so every enable starts a fresh
// half-period.
module spi_clk_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic idle_lvl,
    output logic sclk,
    output logic lead_stb,
    output logic trail_stb
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] hc;
    logic          ph;
    logic          tc;

    assign tc        = en && (hc == '0);
    assign lead_stb  = tc && !ph;
    assign trail_stb = tc && ph;

    // Half-period counter, edge phase and the registered sclk itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc   <= DW'(DIV - 1);
            ph   <= 1'b0;
            sclk <= 1'b0;
        end else if (!en) begin
            hc   <= DW'(DIV - 1);
            ph   <= 1'b0;
            sclk <= idle_lvl;
        end else if (tc) begin
            hc   <= DW'(DIV - 1);
            ph   <= ~ph;
            sclk <= ~sclk;
        end else begin
            hc   <= hc - DW'(1);
        end
    end

endmodule

// File: rtl/spi_main_multi.sv
// SPI main controller with run-time frame length, all CPOL/CPHA modes and
// several chip-selects.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; sclk follows the cpol input
//   ST_SETUP | cs asserted, sclk at cpol, first bit on mosi (cpha=0)
//   ST_XFER  | len bits clocked, each 2*DIV cycles
//   ST_HOLD  | sclk back at cpol, cs still asserted for DIV cycles
//   ST_DONE  | one-cycle done pulse, err valid
//
// cs_sel is one bit wider than strictly needed so an out-of-range select
// can be presented and reported through err.
module spi_main_multi
    import spi_pkg::*;
#(
    parameter int MAX_BITS = MAX_BITS_DEF,
    parameter int DIV      = DIV_DEF,
    parameter int NUM_CS   = 2,
    parameter int LW       = $clog2(MAX_BITS + 1),
    parameter int CSW      = $clog2(NUM_CS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LW-1:0]       len,
    input  logic [CSW-1:0]      cs_sel,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [MAX_BITS-1:0] tx,
    input  logic                miso,
    output logic                sclk,
    output logic                mosi,
    output logic [NUM_CS-1:0]   cs_n,
    output logic [MAX_BITS-1:0] rx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    spi_state_e          state, state_nxt;
    spi_mode_t           mode_q;
    logic [CSW-1:0]      sel_q, sel_eff;
    logic [LW-1:0]       len_c, len_q, bit_cnt, mask_len;
    logic [MAX_BITS-1:0] tx_sr, len_mask;
    logic [DW-1:0]       tmr;
    logic [NUM_CS-1:0]   cs_n_d;
    logic                sel_bad, accept, xfer_go, lvl;
    logic                lead_stb, trail_stb, sample, shift;

    assign len_c    = (len > LW'(MAX_BITS)) ? LW'(MAX_BITS) : len;
    assign sel_bad  = (cs_sel >= CSW'(NUM_CS));
    assign accept   = (state == ST_IDLE) && start;
    assign xfer_go  = accept && !sel_bad && (len_c != '0);
    assign sample   = (state == ST_XFER) && (mode_q.cpha ? trail_stb : lead_stb);
    assign shift    = (state == ST_XFER) && (mode_q.cpha ? lead_stb : trail_stb);
    assign mask_len = (state == ST_IDLE) ? len_c : len_q;
    assign sel_eff  = (state == ST_IDLE) ? cs_sel : sel_q;
    assign lvl      = (state == ST_IDLE) ? cpol : mode_q.cpol;

    spi_clk_gen #(.DIV(DIV)) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state == ST_XFER),
        .idle_lvl  (lvl),
        .sclk      (sclk),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    // Mask of the active frame bits; rx is kept zero above len-1.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_BITS; i++) len_mask[i] = (i < int'(mask_len));
    end

    // Next-state, status flags and the chip-select pattern for the next cycle.
    always_comb begin
        state_nxt = state;
        cs_n_d    = '1;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE:  if (start) state_nxt = xfer_go ? ST_SETUP : ST_DONE;
            ST_SETUP: if (tmr == '0) state_nxt = ST_XFER;
            ST_XFER:  if (trail_stb && (bit_cnt == LW'(1))) state_nxt = ST_HOLD;
            ST_HOLD:  if (tmr == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_SETUP || state_nxt == ST_XFER || state_nxt == ST_HOLD) begin
            for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (sel_eff != CSW'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // SETUP/HOLD duration timer, reloaded on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  tmr <= DW'(DIV - 1);
        else if (state_nxt != state) tmr <= DW'(DIV - 1);
        else if (tmr != '0)          tmr <= tmr - DW'(1);
    end

    // Shadow registers, shift datapath, chip-selects and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx      <= '0;
            mosi    <= 1'b0;
            mode_q  <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
            cs_n    <= '1;
        end else begin
            cs_n <= cs_n_d;
            err  <= accept && sel_bad;
            if (accept) begin
                tx_sr   <= tx;
                mode_q  <= {cpol, cpha};
                sel_q   <= cs_sel;
                len_q   <= len_c;
                bit_cnt <= len_c;
                rx      <= rx & len_mask;
                if (xfer_go && !cpha) mosi <= tx[MAX_BITS-1];
            end else begin
                if (shift) begin
                    mosi  <= mode_q.cpha ? tx_sr[MAX_BITS-1] : tx_sr[MAX_BITS-2];
                    tx_sr <= {tx_sr[MAX_BITS-2:0], 1'b0};
                end
                if (sample) rx <= {rx[MAX_BITS-2:0], miso} & len_mask;
                if ((state == ST_XFER) && trail_stb) bit_cnt <= bit_cnt - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_main_multi.sv
// Directed bench for spi_main_multi: vector table plus restart, slave and
// reset-mid-frame sequences.
module tb_spi_main_multi;

    localparam int MB = 258;

    logic          clk = 1'b0;
    logic          rst_n, start, cpol, cpha, miso;
    logic [8:0]    len;
    logic [1:0]    cs_sel;
    logic [MB-1:0] tx, rx;
    logic          sclk, mosi, busy, done, err;
    logic [1:0]    cs_n;

    int errors = 0;
    int checks = 0;

    spi_main_multi dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .tx(tx), .miso(miso), .sclk(sclk),
        .mosi(mosi), .cs_n(cs_n), .rx(rx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int sclk_edges = 0;
    int done_cnt   = 0;
    always @(sclk) sclk_edges++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Simple mode-0 slave on cs 1: shifts a fixed response out MSB first.
    logic         slave_en = 1'b0;
    logic [127:0] slv_resp = 128'h00112233445566778899aabbccddeeff;
    logic [6:0]   slv_idx  = 7'd127;
    always @(posedge sclk or posedge cs_n[1]) begin
        if (cs_n[1])           slv_idx = 7'd127;
        else if (slv_idx != 0) slv_idx = slv_idx - 7'd1;
    end
    assign miso = slave_en ? slv_resp[slv_idx] : mosi;

    typedef struct {
        logic [MB-1:0] tx;
        logic [8:0]    len;
        logic [1:0]    sel;
        logic          pol;
        logic          pha;
        logic          chk_rx;
        logic [MB-1:0] rx;
        int            lat;
        logic          err;
        logic [1:0]    cs;
        int            edges;
    } vec_t;

    vec_t v[7];

    task automatic chk(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input logic [MB-1:0] t, input logic [8:0] l, input logic [1:0] sel,
                           input logic pol, input logic pha, input logic [1:0] exp_cs,
                           input int restart_at, output int lat_o, output logic err_o,
                           output int cs_bad_o, output int edges_o,
                           output logic sclk_pre, output logic sclk_end);
        int e0;
        int n;
        int bad;
        @(negedge clk);
        tx = t; len = l; cs_sel = sel; cpol = pol; cpha = pha;
        @(negedge clk);
        e0 = sclk_edges;
        sclk_pre = sclk;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tx = ~t; len = 9'd3; cs_sel = ~sel; cpha = ~pha;
        n = 1;
        bad = 0;
        while (!done && n < 3000) begin
            if (busy && cs_n !== exp_cs) bad++;
            start = (n == restart_at);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        if (cs_n !== 2'b11) bad++;
        lat_o    = n;
        err_o    = err;
        cs_bad_o = bad;
        edges_o  = sclk_edges - e0;
        sclk_end = sclk;
    endtask

    initial begin
        int   lat, csb, edg, db, n;
        logic e, sp, se;

        v[0] = '{tx: {128'h000102030405060708090a0b0c0d0e0f, 130'b0}, len: 9'd128, sel: 2'd0,
                 pol: 1'b0, pha: 1'b0, chk_rx: 1'b1, rx: {130'b0, 128'h000102030405060708090a0b0c0d0e0f},
                 lat: 517, err: 1'b0, cs: 2'b10, edges: 256};
        v[1] = '{tx: {8'ha5, 250'b0}, len: 9'd8, sel: 2'd1, pol: 1'b1, pha: 1'b1, chk_rx: 1'b1,
                 rx: {250'b0, 8'ha5}, lat: 37, err: 1'b0, cs: 2'b01, edges: 16};
        v[2] = '{tx: {5'b10110, 253'b0}, len: 9'd5, sel: 2'd0, pol: 1'b0, pha: 1'b1, chk_rx: 1'b1,
                 rx: {253'b0, 5'b10110}, lat: 25, err: 1'b0, cs: 2'b10, edges: 10};
        v[3] = '{tx: {2'b10, {8{32'hdeadbeef}}}, len: 9'd258, sel: 2'd1, pol: 1'b1, pha: 1'b0,
                 chk_rx: 1'b1, rx: {2'b10, {8{32'hdeadbeef}}}, lat: 1037, err: 1'b0, cs: 2'b01, edges: 516};
        v[4] = '{tx: {MB{1'b1}}, len: 9'd0, sel: 2'd0, pol: 1'b0, pha: 1'b0, chk_rx: 1'b0,
                 rx: '0, lat: 1, err: 1'b0, cs: 2'b11, edges: 0};
        v[5] = '{tx: {MB{1'b1}}, len: 9'd16, sel: 2'd2, pol: 1'b0, pha: 1'b0, chk_rx: 1'b0,
                 rx: '0, lat: 1, err: 1'b1, cs: 2'b11, edges: 0};
        v[6] = '{tx: {2'b01, {4{64'h0123456789abcdef}}}, len: 9'd300, sel: 2'd0, pol: 1'b0, pha: 1'b0,
                 chk_rx: 1'b1, rx: {2'b01, {4{64'h0123456789abcdef}}}, lat: 1037, err: 1'b0, cs: 2'b10, edges: 516};

        rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
        len = '0; cs_sel = '0; tx = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 2'b11);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_rx", rx, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            db = done_cnt;
            do_xfer(v[i].tx, v[i].len, v[i].sel, v[i].pol, v[i].pha, v[i].cs, -1,
                    lat, e, csb, edg, sp, se);
            chk($sformatf("v%0d_latency", i), lat, v[i].lat);
            chk($sformatf("v%0d_err", i), e, v[i].err);
            chk($sformatf("v%0d_cs_bad_cycles", i), csb, 0);
            chk($sformatf("v%0d_sclk_edges", i), edg, v[i].edges);
            chk($sformatf("v%0d_sclk_idle", i), {sp, se}, {v[i].pol, v[i].pol});
            if (v[i].chk_rx) chk($sformatf("v%0d_rx", i), rx, v[i].rx);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_done_pulses", i), done_cnt - db, 1);
        end

        // Second start at cycle 50 of a 128-bit frame must be ignored.
        db = done_cnt;
        do_xfer(v[0].tx, v[0].len, 2'd0, 1'b0, 1'b0, 2'b10, 50, lat, e, csb, edg, sp, se);
        chk("restart_latency", lat, 517);
        chk("restart_rx", rx, v[0].rx);
        repeat (600) @(negedge clk);
        chk("restart_done_pulses", done_cnt - db, 1);

        // Non-loopback slave on cs 1 answering a ciphertext frame.
        slave_en = 1'b1;
        do_xfer({128'h8ea2b7ca516745bfeafc49904b496089, 130'b0}, 9'd128, 2'd1, 1'b0, 1'b0, 2'b01, -1,
                lat, e, csb, edg, sp, se);
        slave_en = 1'b0;
        chk("slave_rx", rx, {130'b0, 128'h00112233445566778899aabbccddeeff});
        chk("slave_latency", lat, 517);
        chk("slave_cs_bad_cycles", csb, 0);

        // Reset while bit 60 has sclk high.
        @(negedge clk);
        tx = v[0].tx; len = 9'd128; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        db = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (!(n >= 245 && sclk === 1'b1) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_reset_bit_cycle", n, 245);
        chk("pre_reset_cs_n", cs_n, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_cs_n", cs_n, 2'b11);
        chk("mid_reset_sclk", sclk, 1'b0);
        chk("mid_reset_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_reset_no_done", done_cnt - db, 0);
        do_xfer(v[0].tx, v[0].len, 2'd0, 1'b0, 1'b0, 2'b10, -1, lat, e, csb, edg, sp, se);
        chk("post_reset_rx", rx, v[0].rx);
        chk("post_reset_latency", lat, 517);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
